// File: rtl/pipe_sched_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM encoding and the
// pipeline-register control bundles used by the scheduler.
package pipe_sched_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WD_W       = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_load;
    logic ifid_load;
    logic ifid_flush;
    logic idex_load;
    logic idex_flush;
    logic exmem_load;
    logic memwb_load;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_STALL    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_FLUSH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Data access completes: the stolen fetch slot enters IF/ID as a bubble.
  localparam ctrl_t CTRL_MEM_STEP = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/pipe_sched_if.sv
// Control/status bundle between the core datapath (master) and the pipeline
// sequencer (slave).
interface pipe_sched_if
  import pipe_sched_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  wb_halt;

  logic                  pc_load;
  logic                  ifid_load;
  logic                  ifid_flush;
  logic                  idex_load;
  logic                  idex_flush;
  logic                  exmem_load;
  logic                  memwb_load;
  logic                  mem_sel;
  logic                  halted;
  logic                  mem_err;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           mem_req, mem_ready, wb_halt,
    input  pc_load, ifid_load, ifid_flush, idex_load, idex_flush,
           exmem_load, memwb_load, mem_sel, halted, mem_err,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken,
           mem_req, mem_ready, wb_halt,
    output pc_load, ifid_load, ifid_flush, idex_load, idex_flush,
           exmem_load, memwb_load, mem_sel, halted, mem_err,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_sched_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination (other than x0)
// is read by the instruction in ID.
module hazard_detect
  import pipe_sched_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  hazard
);
  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));
endmodule

// File: rtl/pipe_sched.sv
// Pipeline sequencer for the 5-stage core: pipeline-register load/flush, memory
// port arbitration, MEM watchdog and halt. Statistics counters: PIPE_SCHED_STATS_EN.
module pipe_sched
  import pipe_sched_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
)(
  input logic        clk,
  input logic        rst,
  pipe_sched_if.slave bus
);

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            mem_err_q, mem_err_d;
  ctrl_t           ctrl;
  ctrl_t           step_ctrl;
  logic            mem_sel;
  logic            halted;
  logic            hazard;

  hazard_detect u_hazard (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .ex_rd       (bus.ex_rd),
    .ex_mem_read (bus.ex_mem_read),
    .hazard      (hazard)
  );

  // A taken branch on the data-access advance loads the target PC directly.
  always_comb begin
    step_ctrl = CTRL_MEM_STEP;
    if (bus.ex_branch_taken) begin
      step_ctrl.pc_load    = 1'b1;
      step_ctrl.idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    mem_err_d = mem_err_q;
    ctrl      = CTRL_FREEZE;
    mem_sel   = 1'b0;
    halted    = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.mem_req) begin
          mem_sel = 1'b1;
          if (bus.mem_ready) begin
            ctrl = step_ctrl;
          end else begin
            state_d = MEM_WAIT;
            wd_d    = WD_W'(1);
          end
        end else if (bus.ex_branch_taken) begin
          ctrl = CTRL_FLUSH;
        end else if (hazard) begin
          ctrl = CTRL_STALL;
        end else begin
          ctrl = CTRL_ADVANCE;
        end
      end
      MEM_WAIT: begin
        mem_sel = 1'b1;
        if (bus.mem_ready) begin
          ctrl    = step_ctrl;
          state_d = RUN;
          wd_d    = '0;
        end else if (wd_q >= WD_W'(MEM_TIMEOUT)) begin
          mem_err_d = 1'b1;
          state_d   = HALT;
          wd_d      = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = RUN;
        wd_d    = '0;
      end
    endcase

    // The retiring halt keeps this cycle's controls but drops any pending access.
    if (bus.wb_halt && (state_q != HALT)) begin
      state_d = HALT;
      wd_d    = '0;
    end

    if (rst) begin
      state_d   = RUN;
      wd_d      = '0;
      mem_err_d = 1'b0;
      ctrl      = CTRL_FREEZE;
      mem_sel   = 1'b0;
      halted    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    wd_q      <= wd_d;
    mem_err_q <= mem_err_d;
  end

  assign bus.pc_load    = ctrl.pc_load;
  assign bus.ifid_load  = ctrl.ifid_load;
  assign bus.ifid_flush = ctrl.ifid_flush;
  assign bus.idex_load  = ctrl.idex_load;
  assign bus.idex_flush = ctrl.idex_flush;
  assign bus.exmem_load = ctrl.exmem_load;
  assign bus.memwb_load = ctrl.memwb_load;
  assign bus.mem_sel    = mem_sel;
  assign bus.halted     = halted;
  assign bus.mem_err    = mem_err_q && !rst;

`ifdef PIPE_SCHED_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Both counters saturate at all-ones.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((state_q != HALT) && !ctrl.pc_load && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
    if ((ctrl.ifid_flush || ctrl.idex_flush) && (flush_q != '1))
      flush_d = flush_q + CNT_W'(1);
    if (rst) begin
      stall_d = '0;
      flush_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    stall_q <= stall_d;
    flush_q <= flush_d;
  end

  assign bus.stall_cycles = rst ? '0 : stall_q;
  assign bus.flush_count  = rst ? '0 : flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// Directed scoreboard bench for pipe_sched: each step drives one cycle of
// stimulus, queues the expected controls and checks them on the falling edge.
module tb_pipe_sched;
  import pipe_sched_pkg::*;

  localparam int CNT_W = 32;

  // {pc_load, ifid_load, ifid_flush, idex_load, idex_flush, exmem_load,
  //  memwb_load, mem_sel, halted, mem_err}
  localparam logic [9:0] E_ZERO     = 10'b0000000000;
  localparam logic [9:0] E_RUN      = 10'b1101011000;
  localparam logic [9:0] E_STALL    = 10'b0001111000;
  localparam logic [9:0] E_FLUSH    = 10'b1111111000;
  localparam logic [9:0] E_FREEZE   = 10'b0000000100;
  localparam logic [9:0] E_MEMADV   = 10'b0111011100;
  localparam logic [9:0] E_MEMADV_B = 10'b1111111100;
  localparam logic [9:0] E_HALT     = 10'b0000000010;
  localparam logic [9:0] E_HALT_ERR = 10'b0000000011;

  typedef struct {
    string      tag;
    logic [9:0] vec;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   total_checks;
  int   passed_checks;
  int   exp_stall;
  int   exp_flush;

  pipe_sched_if #(.CNT_W(CNT_W)) bus ();

  pipe_sched #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input string tag, input logic r,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic mrd,
                               input logic br, input logic mq, input logic my,
                               input logic wh, input logic [9:0] e);
    exp_t item;
    rst                 = r;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    bus.ex_rd           = rd;
    bus.ex_mem_read     = mrd;
    bus.ex_branch_taken = br;
    bus.mem_req         = mq;
    bus.mem_ready       = my;
    bus.wb_halt         = wh;
    item.tag = tag;
    item.vec = e;
    sb.push_back(item);
  endtask

  task automatic checkOutput();
    exp_t       item;
    logic [9:0] obs;
    @(negedge clk);
    obs = {bus.pc_load, bus.ifid_load, bus.ifid_flush, bus.idex_load,
           bus.idex_flush, bus.exmem_load, bus.memwb_load, bus.mem_sel,
           bus.halted, bus.mem_err};
    total_checks++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: observed %b required queued entry", obs);
    end else begin
      item = sb.pop_front();
      assert (obs === item.vec) passed_checks++;
      else $error("[TB] FAIL %s: observed %b expected %b", item.tag, obs, item.vec);
`ifdef PIPE_SCHED_STATS_EN
      total_checks++;
      assert (bus.stall_cycles === CNT_W'(rst ? 0 : exp_stall)) passed_checks++;
      else $error("[TB] FAIL %s_stall_cycles: observed %0d expected %0d",
                  item.tag, bus.stall_cycles, rst ? 0 : exp_stall);
      total_checks++;
      assert (bus.flush_count === CNT_W'(rst ? 0 : exp_flush)) passed_checks++;
      else $error("[TB] FAIL %s_flush_count: observed %0d expected %0d",
                  item.tag, bus.flush_count, rst ? 0 : exp_flush);
      if (rst) begin
        exp_stall = 0;
        exp_flush = 0;
      end else begin
        if (!item.vec[1] && !item.vec[9]) exp_stall++;
        if (item.vec[7] || item.vec[5]) exp_flush++;
      end
`else
      total_checks++;
      assert (bus.stall_cycles === '0 && bus.flush_count === '0) passed_checks++;
      else $error("[TB] FAIL %s_stats_tied: observed %0d/%0d expected 0/0",
                  item.tag, bus.stall_cycles, bus.flush_count);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mrd, input logic br,
                      input logic mq, input logic my, input logic wh,
                      input logic [9:0] e);
    applyStimulus(tag, r, rs1, rs2, rd, mrd, br, mq, my, wh, e);
    checkOutput();
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    exp_stall     = 0;
    exp_flush     = 0;

    //    tag              rst rs1 rs2 rd  mrd br mq my wh expected
    step("reset_idle",     1, 0,  0,  0,  0,  0, 0, 0, 0, E_ZERO);
    step("reset_gated",    1, 5,  0,  5,  1,  1, 1, 0, 1, E_ZERO);
    step("run_idle",       0, 1,  2,  3,  0,  0, 0, 0, 0, E_RUN);
    step("loaduse_rs1",    0, 5,  0,  5,  1,  0, 0, 0, 0, E_STALL);
    step("after_bubble",   0, 5,  0,  0,  0,  0, 0, 0, 0, E_RUN);
    step("loaduse_rs2",    0, 1,  7,  7,  1,  0, 0, 0, 0, E_STALL);
    step("x0_no_stall",    0, 0,  0,  0,  1,  0, 0, 0, 0, E_RUN);
    step("load_no_match",  0, 4,  5,  3,  1,  0, 0, 0, 0, E_RUN);
    step("branch_vs_lu",   0, 5,  0,  5,  1,  1, 0, 0, 0, E_FLUSH);
    step("mem_ready_now",  0, 0,  0,  0,  0,  0, 1, 1, 0, E_MEMADV);
    step("mem_adv_branch", 0, 0,  0,  0,  0,  1, 1, 1, 0, E_MEMADV_B);

    step("wait_enter",     0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("wait_1",         0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("wait_2",         0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("wait_done",      0, 0,  0,  0,  0,  0, 1, 1, 0, E_MEMADV);
    step("back_in_run",    0, 0,  0,  0,  0,  0, 0, 0, 0, E_RUN);

    step("wd_enter",       0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("wd_1",           0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("wd_2",           0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("wd_3",           0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("wd_4_expire",    0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("wd_halted",      0, 0,  0,  0,  0,  0, 0, 0, 0, E_HALT_ERR);
    step("wd_sticky",      0, 5,  0,  5,  1,  1, 1, 1, 0, E_HALT_ERR);
    step("wd_reset",       1, 0,  0,  0,  0,  0, 0, 0, 0, E_ZERO);
    step("wd_cleared",     0, 0,  0,  0,  0,  0, 0, 0, 0, E_RUN);

    step("race_enter",     0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("race_1",         0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("race_2",         0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("race_3",         0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("race_ready_wins",0, 0,  0,  0,  0,  0, 1, 1, 0, E_MEMADV);
    step("race_run",       0, 0,  0,  0,  0,  0, 0, 0, 0, E_RUN);

    step("rstwait_enter",  0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("rstwait_1",      0, 0,  0,  0,  0,  0, 1, 0, 0, E_FREEZE);
    step("rstwait_rst",    1, 0,  0,  0,  0,  0, 1, 0, 0, E_ZERO);
    step("rstwait_run",    0, 0,  0,  0,  0,  0, 0, 0, 0, E_RUN);

    step("halt_in_wait",   0, 0,  0,  0,  0,  0, 1, 0, 1, E_FREEZE);
    step("halt_drop",      0, 0,  0,  0,  0,  0, 1, 1, 0, E_HALT);
    step("halt_rst",       1, 0,  0,  0,  0,  0, 0, 0, 0, E_ZERO);
    step("halt_run_cycle", 0, 0,  0,  0,  0,  0, 0, 0, 1, E_RUN);
    step("halt_frozen",    0, 0,  0,  0,  0,  1, 0, 0, 0, E_HALT);
    step("halt_held",      0, 3,  0,  3,  1,  0, 0, 0, 0, E_HALT);
    step("halt_rst_2",     1, 0,  0,  0,  0,  0, 0, 0, 0, E_ZERO);
    step("final_run",      0, 0,  0,  0,  0,  0, 0, 0, 0, E_RUN);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
